// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions used by the ID/EX issue stage.
//   XLEN        - datapath width
//   reg_idx_t   - architectural register index (x0..x31)
//   alu_op_e    - ALU operation encoding driven on alu_ctrl
//   ex_entry_t  - payload held in the ID/EX pipeline register
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8
    } alu_op_e;

    // An all-zero entry decodes as ALU_ADD with every field cleared.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        alu_op_e         alu_ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] store_data;
        reg_idx_t        rd;
        logic            reg_we;
        logic            is_load;
    } ex_entry_t;

endpackage

// File: rtl/id_ex_issue_if.sv
// Bundle between the decode stage, the later pipeline stages and the
// ID/EX issue stage.
//   decode side : flush, dec_valid/dec_ready handshake, dec_* fields
//   feedback    : alu_result (EX), mem_*/wb_* forwarding sources
//   EX side     : ex_valid/ex_ready handshake, ex_* fields to the ALU
//   status      : bubble_cnt (saturating load-use bubble count)
// The slave modport belongs to id_ex_issue; the master modport belongs
// to whatever surrounds it.
interface id_ex_issue_if
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             flush;
    logic             dec_valid;
    logic             dec_ready;
    logic [XLEN-1:0]  dec_pc;
    alu_op_e          dec_alu_ctrl;
    reg_idx_t         dec_rs1;
    reg_idx_t         dec_rs2;
    reg_idx_t         dec_rd;
    logic             dec_uses_rs1;
    logic             dec_uses_rs2;
    logic [XLEN-1:0]  dec_rs1_val;
    logic [XLEN-1:0]  dec_rs2_val;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_use_imm;
    logic             dec_reg_we;
    logic             dec_is_load;

    logic [XLEN-1:0]  alu_result;
    reg_idx_t         mem_rd;
    reg_idx_t         wb_rd;
    logic             mem_we;
    logic             wb_we;
    logic [XLEN-1:0]  mem_data;
    logic [XLEN-1:0]  wb_data;

    logic             ex_valid;
    logic             ex_ready;
    alu_op_e          ex_alu_ctrl;
    logic [XLEN-1:0]  ex_a;
    logic [XLEN-1:0]  ex_b;
    logic [XLEN-1:0]  ex_store_data;
    logic [XLEN-1:0]  ex_pc;
    reg_idx_t         ex_rd;
    logic             ex_reg_we;
    logic             ex_is_load;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output flush, dec_valid, dec_pc, dec_alu_ctrl, dec_rs1, dec_rs2, dec_rd,
               dec_uses_rs1, dec_uses_rs2, dec_rs1_val, dec_rs2_val, dec_imm,
               dec_use_imm, dec_reg_we, dec_is_load,
               alu_result, mem_rd, wb_rd, mem_we, wb_we, mem_data, wb_data,
               ex_ready,
        input  dec_ready, ex_valid, ex_alu_ctrl, ex_a, ex_b, ex_store_data,
               ex_pc, ex_rd, ex_reg_we, ex_is_load, bubble_cnt
    );

    modport slave (
        input  flush, dec_valid, dec_pc, dec_alu_ctrl, dec_rs1, dec_rs2, dec_rd,
               dec_uses_rs1, dec_uses_rs2, dec_rs1_val, dec_rs2_val, dec_imm,
               dec_use_imm, dec_reg_we, dec_is_load,
               alu_result, mem_rd, wb_rd, mem_we, wb_we, mem_data, wb_data,
               ex_ready,
        output dec_ready, ex_valid, ex_alu_ctrl, ex_a, ex_b, ex_store_data,
               ex_pc, ex_rd, ex_reg_we, ex_is_load, bubble_cnt
    );

endinterface

// File: rtl/id_ex_issue_operand_fwd.sv
// Combinational operand forwarding for one source register.
//   rs_i                 - source register index
//   rf_val_i             - register-file read data
//   ex_fwd_i             - EX entry holds a forwardable (non-load) result
//   ex_rd_i/ex_val_i     - EX destination and ALU result
//   mem_we_i/rd_i/val_i  - MEM stage write-back source
//   wb_we_i/rd_i/val_i   - WB stage write-back source
//   val_o                - resolved operand (EX > MEM > WB > register file)
module operand_fwd
    import riscv_pkg::*;
(
    input  reg_idx_t        rs_i,
    input  logic [XLEN-1:0] rf_val_i,
    input  logic            ex_fwd_i,
    input  reg_idx_t        ex_rd_i,
    input  logic [XLEN-1:0] ex_val_i,
    input  logic            mem_we_i,
    input  reg_idx_t        mem_rd_i,
    input  logic [XLEN-1:0] mem_val_i,
    input  logic            wb_we_i,
    input  reg_idx_t        wb_rd_i,
    input  logic [XLEN-1:0] wb_val_i,
    output logic [XLEN-1:0] val_o
);

    always_comb begin
        // NOTE: the output gets a default before any branch so every path
        // assigns it and no latch is inferred.
        val_o = rf_val_i;
        if (rs_i == '0) begin
            // x0 is hardwired to zero whatever the stages claim to write.
            val_o = '0;
        end else if (ex_fwd_i && (ex_rd_i == rs_i)) begin
            val_o = ex_val_i;
        end else if (mem_we_i && (mem_rd_i == rs_i)) begin
            val_o = mem_val_i;
        end else if (wb_we_i && (wb_rd_i == rs_i)) begin
            val_o = wb_val_i;
        end
    end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX issue stage: registers one decoded instruction per cycle into the
// ID/EX pipeline register, forwards in-flight results, drives the ALU
// operands straight from that register, inserts one bubble per load-use
// hazard and counts those bubbles.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - id_ex_issue_if slave: decode handshake, forwarding
//                sources, EX handshake/fields and bubble_cnt
module id_ex_issue
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_issue_if.slave bus
);

    logic             advance;
    logic             hazard;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             ex_fwd_en;
    logic [XLEN-1:0]  rs1_fwd;
    logic [XLEN-1:0]  rs2_fwd;
    ex_entry_t        issue_entry;
    ex_entry_t        ex_q, ex_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    assign advance = ~ex_valid_q | bus.ex_ready;

    // A load in EX has no data yet; a dependent instruction must wait one
    // cycle so the value can be picked up from MEM instead.
    assign rs1_hit = bus.dec_uses_rs1 && (bus.dec_rs1 == ex_q.rd);
    assign rs2_hit = bus.dec_uses_rs2 && (bus.dec_rs2 == ex_q.rd);
    assign hazard  = bus.dec_valid & ex_valid_q & ex_q.is_load & ex_q.reg_we
                   & (ex_q.rd != '0) & (rs1_hit | rs2_hit);

    // A flush discards the decode entry, so it is always "accepted".
    assign bus.dec_ready = bus.flush | (advance & ~hazard);

    assign ex_fwd_en = ex_valid_q & ex_q.reg_we & ~ex_q.is_load;

    operand_fwd u_fwd_rs1 (
        .rs_i     (bus.dec_rs1),
        .rf_val_i (bus.dec_rs1_val),
        .ex_fwd_i (ex_fwd_en),
        .ex_rd_i  (ex_q.rd),
        .ex_val_i (bus.alu_result),
        .mem_we_i (bus.mem_we),
        .mem_rd_i (bus.mem_rd),
        .mem_val_i(bus.mem_data),
        .wb_we_i  (bus.wb_we),
        .wb_rd_i  (bus.wb_rd),
        .wb_val_i (bus.wb_data),
        .val_o    (rs1_fwd)
    );

    operand_fwd u_fwd_rs2 (
        .rs_i     (bus.dec_rs2),
        .rf_val_i (bus.dec_rs2_val),
        .ex_fwd_i (ex_fwd_en),
        .ex_rd_i  (ex_q.rd),
        .ex_val_i (bus.alu_result),
        .mem_we_i (bus.mem_we),
        .mem_rd_i (bus.mem_rd),
        .mem_val_i(bus.mem_data),
        .wb_we_i  (bus.wb_we),
        .wb_rd_i  (bus.wb_rd),
        .wb_val_i (bus.wb_data),
        .val_o    (rs2_fwd)
    );

    always_comb begin
        issue_entry.pc         = bus.dec_pc;
        issue_entry.alu_ctrl   = bus.dec_alu_ctrl;
        issue_entry.a          = rs1_fwd;
        issue_entry.b          = bus.dec_use_imm ? bus.dec_imm : rs2_fwd;
        issue_entry.store_data = rs2_fwd;
        issue_entry.rd         = bus.dec_rd;
        issue_entry.reg_we     = bus.dec_reg_we;
        issue_entry.is_load    = bus.dec_is_load;
    end

    always_comb begin
        ex_d         = ex_q;
        ex_valid_d   = ex_valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (advance && hazard) begin
            ex_valid_d = 1'b0;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (advance && bus.dec_valid) begin
            ex_d       = issue_entry;
            ex_valid_d = 1'b1;
        end else if (advance) begin
            // Data fields keep their last value; only validity drops.
            ex_valid_d = 1'b0;
        end
    end

    // NOTE: state registers update with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            ex_valid_q   <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            ex_valid_q   <= ex_valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_alu_ctrl   = ex_q.alu_ctrl;
    assign bus.ex_a          = ex_q.a;
    assign bus.ex_b          = ex_q.b;
    assign bus.ex_store_data = ex_q.store_data;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_we     = ex_q.reg_we;
    assign bus.ex_is_load    = ex_q.is_load;
    assign bus.bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue. Inputs change on the falling edge;
// registered outputs are sampled on the following falling edge and
// dec_ready 1 ns after the inputs change.
module tb_id_ex_issue;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    id_ex_issue_if #(.CNT_W(16)) bus ();

    id_ex_issue #(.CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.flush        = 1'b0;
        bus.dec_valid    = 1'b0;
        bus.dec_pc       = '0;
        bus.dec_alu_ctrl = ALU_ADD;
        bus.dec_rs1      = '0;
        bus.dec_rs2      = '0;
        bus.dec_rd       = '0;
        bus.dec_uses_rs1 = 1'b0;
        bus.dec_uses_rs2 = 1'b0;
        bus.dec_rs1_val  = '0;
        bus.dec_rs2_val  = '0;
        bus.dec_imm      = '0;
        bus.dec_use_imm  = 1'b0;
        bus.dec_reg_we   = 1'b0;
        bus.dec_is_load  = 1'b0;
        bus.alu_result   = '0;
        bus.mem_rd       = '0;
        bus.wb_rd        = '0;
        bus.mem_we       = 1'b0;
        bus.wb_we        = 1'b0;
        bus.mem_data     = '0;
        bus.wb_data      = '0;
        bus.ex_ready     = 1'b1;
    endtask

    task automatic dec_set(input alu_op_e op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [31:0] v1,
                           input logic [4:0] rs2, input logic [31:0] v2,
                           input logic use_imm, input logic [31:0] imm,
                           input logic is_load, input logic [31:0] pc);
        bus.dec_valid    = 1'b1;
        bus.dec_alu_ctrl = op;
        bus.dec_rd       = rd;
        bus.dec_rs1      = rs1;
        bus.dec_rs1_val  = v1;
        bus.dec_rs2      = rs2;
        bus.dec_rs2_val  = v2;
        bus.dec_uses_rs1 = 1'b1;
        bus.dec_uses_rs2 = !use_imm;
        bus.dec_use_imm  = use_imm;
        bus.dec_imm      = imm;
        bus.dec_reg_we   = 1'b1;
        bus.dec_is_load  = is_load;
        bus.dec_pc       = pc;
    endtask

    initial begin
        // ---- reset state ----
        rst_n = 1'b0;
        idle();
        #12;
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_ex_a", bus.ex_a, 0);
        check("rst_alu_ctrl", bus.ex_alu_ctrl, ALU_ADD);
        check("rst_bubble_cnt", bus.bubble_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- back-to-back: ADD x1 = 5 + 7, SUB x2 = x1 - 2 ----
        dec_set(ALU_ADD, 5'd1, 5'd10, 32'd5, 5'd11, 32'd7, 1'b0, 32'd0, 1'b0, 32'h100);
        #1 check("b2b_ready0", bus.dec_ready, 1);
        @(negedge clk);
        check("b2b_valid0", bus.ex_valid, 1);
        check("b2b_a0", bus.ex_a, 5);
        check("b2b_b0", bus.ex_b, 7);
        check("b2b_sdata0", bus.ex_store_data, 7);
        bus.alu_result = 32'd12;
        dec_set(ALU_SUB, 5'd2, 5'd1, 32'hDEAD, 5'd0, 32'd0, 1'b1, 32'd2, 1'b0, 32'h104);
        #1 check("b2b_ready1", bus.dec_ready, 1);
        @(negedge clk);
        check("b2b_valid1", bus.ex_valid, 1);
        check("b2b_a1_exfwd", bus.ex_a, 12);
        check("b2b_b1_imm", bus.ex_b, 2);
        check("b2b_ctrl1", bus.ex_alu_ctrl, ALU_SUB);
        check("b2b_pc1", bus.ex_pc, 32'h104);
        check("b2b_no_bubble", bus.bubble_cnt, 0);

        // ---- load-use: LW x3, then ADD x4 = x3 + x0 ----
        bus.alu_result = 32'd10;
        dec_set(ALU_ADD, 5'd3, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 32'h40, 1'b1, 32'h108);
        @(negedge clk);
        check("lu_load_in_ex", bus.ex_is_load, 1);
        check("lu_load_rd", bus.ex_rd, 3);
        dec_set(ALU_ADD, 5'd4, 5'd3, 32'h77, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h10C);
        #1 check("lu_stall_ready", bus.dec_ready, 0);
        @(negedge clk);
        check("lu_bubble_valid", bus.ex_valid, 0);
        check("lu_bubble_cnt", bus.bubble_cnt, 1);
        bus.mem_we   = 1'b1;
        bus.mem_rd   = 5'd3;
        bus.mem_data = 32'h55;
        #1 check("lu_ready_after", bus.dec_ready, 1);
        @(negedge clk);
        check("lu_issue_valid", bus.ex_valid, 1);
        check("lu_a_memfwd", bus.ex_a, 32'h55);
        check("lu_b", bus.ex_b, 0);
        check("lu_rd", bus.ex_rd, 4);
        check("lu_cnt_kept", bus.bubble_cnt, 1);
        bus.mem_we = 1'b0;

        // ---- forwarding priority on rs1 = x5 ----
        dec_set(ALU_ADD, 5'd5, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h110);
        @(negedge clk);
        bus.alu_result = 32'd1;
        bus.mem_we = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 32'd2;
        bus.wb_we  = 1'b1; bus.wb_rd  = 5'd5; bus.wb_data  = 32'd3;
        dec_set(ALU_ADD, 5'd6, 5'd5, 32'd4, 5'd0, 32'd0, 1'b1, 32'd0, 1'b0, 32'h114);
        @(negedge clk);
        check("prio_ex", bus.ex_a, 1);
        dec_set(ALU_ADD, 5'd7, 5'd5, 32'd4, 5'd0, 32'd0, 1'b1, 32'd0, 1'b0, 32'h118);
        @(negedge clk);
        check("prio_mem", bus.ex_a, 2);
        bus.mem_we = 1'b0;
        dec_set(ALU_ADD, 5'd8, 5'd5, 32'd4, 5'd0, 32'd0, 1'b1, 32'd0, 1'b0, 32'h11C);
        @(negedge clk);
        check("prio_wb", bus.ex_a, 3);
        bus.wb_we = 1'b0;
        dec_set(ALU_ADD, 5'd9, 5'd5, 32'h44, 5'd0, 32'd0, 1'b1, 32'd0, 1'b0, 32'h120);
        @(negedge clk);
        check("prio_rf", bus.ex_a, 32'h44);

        // ---- x0 never forwarded ----
        dec_set(ALU_ADD, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 32'd9, 1'b0, 32'h124);
        @(negedge clk);
        bus.alu_result = 32'd9;
        bus.mem_we = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'd9;
        bus.wb_we  = 1'b1; bus.wb_rd  = 5'd0; bus.wb_data  = 32'd9;
        dec_set(ALU_OR, 5'd9, 5'd0, 32'd9, 5'd0, 32'd9, 1'b0, 32'd0, 1'b0, 32'h128);
        @(negedge clk);
        check("x0_a", bus.ex_a, 0);
        check("x0_b", bus.ex_b, 0);
        check("x0_sdata", bus.ex_store_data, 0);
        bus.mem_we = 1'b0;
        bus.wb_we  = 1'b0;

        // ---- backpressure: ex_ready low for 3 cycles ----
        bus.ex_ready = 1'b0;
        dec_set(ALU_XOR, 5'd10, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 32'd1, 1'b0, 32'h200);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready_low", bus.dec_ready, 0);
            @(negedge clk);
            check("bp_valid_hold", bus.ex_valid, 1);
            check("bp_pc_hold", bus.ex_pc, 32'h128);
            check("bp_ctrl_hold", bus.ex_alu_ctrl, ALU_OR);
        end
        bus.ex_ready = 1'b1;
        #1 check("bp_ready_rise", bus.dec_ready, 1);
        @(negedge clk);
        check("bp_accept_pc", bus.ex_pc, 32'h200);
        check("bp_accept_rd", bus.ex_rd, 10);

        // ---- flush in the same cycle as a load-use hazard ----
        dec_set(ALU_ADD, 5'd12, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 32'h8, 1'b1, 32'h300);
        @(negedge clk);
        check("fl_load_we", bus.ex_reg_we, 1);
        dec_set(ALU_ADD, 5'd13, 5'd12, 32'd0, 5'd0, 32'd0, 1'b1, 32'd0, 1'b0, 32'h304);
        bus.flush = 1'b1;
        #1 check("fl_ready", bus.dec_ready, 1);
        @(negedge clk);
        check("fl_valid", bus.ex_valid, 0);
        check("fl_cnt_same", bus.bubble_cnt, 1);
        bus.flush     = 1'b0;
        bus.dec_valid = 1'b0;

        // ---- bubble counter saturation ----
        force dut.bubble_cnt_q = 16'hFFFD;
        #1 release dut.bubble_cnt_q;
        #1 check("sat_preset", bus.bubble_cnt, 16'hFFFD);
        // A load whose base is its own rd stalls on itself: issue, bubble, ...
        dec_set(ALU_ADD, 5'd3, 5'd3, 32'd0, 5'd0, 32'd0, 1'b1, 32'h8, 1'b1, 32'h380);
        repeat (2) @(negedge clk);
        check("sat_fffe", bus.bubble_cnt, 16'hFFFE);
        repeat (2) @(negedge clk);
        check("sat_ffff", bus.bubble_cnt, 16'hFFFF);
        repeat (2) @(negedge clk);
        check("sat_stick", bus.bubble_cnt, 16'hFFFF);
        check("sat_bubble_valid", bus.ex_valid, 0);

        // ---- asynchronous reset mid-stream ----
        dec_set(ALU_SUB, 5'd14, 5'd20, 32'h1234, 5'd21, 32'h10, 1'b0, 32'd0, 1'b0, 32'h400);
        @(negedge clk);
        check("mid_valid", bus.ex_valid, 1);
        check("mid_a", bus.ex_a, 32'h1234);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.ex_valid, 0);
        check("mid_rst_a", bus.ex_a, 0);
        check("mid_rst_b", bus.ex_b, 0);
        check("mid_rst_pc", bus.ex_pc, 0);
        check("mid_rst_rd", bus.ex_rd, 0);
        check("mid_rst_ctrl", bus.ex_alu_ctrl, ALU_ADD);
        check("mid_rst_cnt", bus.bubble_cnt, 0);
        bus.dec_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_reissue", bus.ex_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

Decode-to-execute issue stage: registers one decoded instruction per cycle into the ID/EX pipeline register, forwards in-flight results to resolve RAW hazards, and drives the combinational `ALU` operands (`alu_ctrl`, `a`, `b`) directly from its output register. It detects load-use hazards and inserts one-cycle bubbles. It also honours a branch/exception flush and counts inserted bubbles.

## Interface
- `XLEN`, 32, datapath width
- `CNT_W`, 16, bubble-counter width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  kill the EX-stage entry and the incoming decode entry
- `dec_valid`  in  1  decode entry present
- `dec_ready`  out  1  entry accepted this cycle
- `dec_pc`  in  XLEN  instruction PC
- `dec_alu_ctrl`  in  4  ALU op (`alu_op_e`)
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  register indices
- `dec_uses_rs1`, `dec_uses_rs2`  in  1 each  operand is read
- `dec_rs1_val`, `dec_rs2_val`  in  XLEN each  register-file read data
- `dec_imm`  in  XLEN  sign-extended immediate
- `dec_use_imm`  in  1  ALU `b` = immediate
- `dec_reg_we`, `dec_is_load`  in  1 each  writes rd / is a load
- `alu_result`  in  XLEN  combinational ALU output for the current EX entry
- `mem_rd`, `wb_rd`  in  5 each  destination regs in MEM/WB
- `mem_we`, `wb_we`  in  1 each  those stages write rd
- `mem_data`, `wb_data`  in  XLEN each  forwardable results
- `ex_valid`  out  1  EX entry valid
- `ex_ready`  in  1  downstream accepts the EX entry
- `ex_alu_ctrl`  out  4  to ALU `alu_ctrl`
- `ex_a`, `ex_b`  out  XLEN each  to ALU `a`, `b`
- `ex_store_data`  out  XLEN  forwarded rs2 value
- `ex_pc`  out  XLEN  PC of the EX entry
- `ex_rd`  out  5  destination register
- `ex_reg_we`, `ex_is_load`  out  1 each  passed-through control
- `bubble_cnt`  out  CNT_W  load-use bubbles inserted, saturating

## Operation
- `advance = ~ex_valid | ex_ready`.
- Hazard condition. `hazard` = `dec_valid & ex_valid & ex_is_load & ex_reg_we & (ex_rd != 0)` AND one of:
  - `dec_uses_rs1` and `dec_rs1 == ex_rd`
  - `dec_uses_rs2` and `dec_rs2 == ex_rd`
- `dec_ready = flush | (advance & ~hazard)`.
- Forwarding applies to rs1 and rs2 independently. Priority: EX > MEM > WB > register file.
  - EX source: `ex_valid & ex_reg_we & ~ex_is_load & ex_rd == rs`, value `alu_result`.
  - MEM source: `mem_we & mem_rd == rs`, value `mem_data`.
  - WB source: `wb_we & wb_rd == rs`, value `wb_data`.
  - Register index 0 is never forwarded; it always reads 0.
- Operand selection:
  - `a` = forwarded rs1.
  - `b` = `dec_use_imm ? dec_imm : forwarded rs2`.
  - `store_data` = forwarded rs2.
- Register update, evaluated in priority order at each `clk` edge:
  1. `flush`: `ex_valid <= 0`; decode entry consumed and discarded.
  2. `advance & hazard`: `ex_valid <= 0` (bubble); `bubble_cnt` increments and saturates at all-ones.
  3. `advance & dec_valid`: all `ex_*` fields load; `ex_valid <= 1`.
  4. `advance & ~dec_valid`: `ex_valid <= 0`.
  5. Otherwise: hold all fields.
- Data fields may load while `ex_valid` is 0. Consumers qualify them with `ex_valid`.

## Timing
- Issue latency is 1 cycle from decode handshake to `ex_valid`.
- Full throughput is 1 entry per cycle with no hazards.
- A load-use hazard costs exactly 1 bubble.
  - In the next cycle the load has moved to MEM and is forwarded from `mem_data`.
- `dec_ready` is combinational from `dec_*`, the `ex_*` registers, `ex_ready` and `flush`.
- Output changes happen only at `clk` edges. Holds are stable while `ex_valid & ~ex_ready`.
- Reset (`rst_n` low, asynchronous): `ex_valid` = 0, all `ex_*` data fields = 0 (`ex_alu_ctrl` = ADD), `bubble_cnt` = 0.
- Reset asserted mid-stream discards the EX entry. No entry is reissued after release.
- Simultaneous `flush` and `hazard`: flush wins. `bubble_cnt` does not increment.

## Structure
- Shared package `riscv_pkg` holds:
  - `alu_op_e`: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8
  - `XLEN`
  - `reg_idx_t` (5-bit)
- One sub-module, `operand_fwd`: purely combinational; one instance per source operand (rs1, rs2).
- Hazard logic, handshake and registers live in `id_ex_issue`.

## Test plan
- Back-to-back ALU ops:
  - Stimulus: ADD x1=5+7, then SUB x2=x1-2, `ex_ready`=1.
  - Required: second entry issues next cycle with `ex_a`=12 (EX forward) and `ex_b`=2; no bubble.
- Load-use:
  - Stimulus: load x3 in EX, then ADD x4=x3+x0; `mem_data`=0x55 in the following cycle.
  - Required: 1 cycle with `dec_ready`=0 and an `ex_valid`=0 bubble; ADD then issues with `ex_a`=0x55; `bubble_cnt`=1.
- Priority:
  - Stimulus: rs1=x5 with EX result 1, MEM 2, WB 3.
  - Required: `ex_a`=1.
  - Stimulus: rs1=x0 with all stages writing x0=9.
  - Required: `ex_a`=0.
- Backpressure:
  - Stimulus: `ex_ready`=0 for 3 cycles with `dec_valid`=1.
  - Required: `dec_ready`=0 throughout; `ex_*` stable; entry accepted the cycle after `ex_ready` rises.
- Flush with hazard:
  - Stimulus: `flush`=1 in the same cycle as a load-use hazard.
  - Required: `ex_valid`=0 next cycle, `dec_ready`=1, `bubble_cnt` unchanged.
- Reset:
  - Stimulus: `rst_n` low mid-stream, plus a saturation check with `bubble_cnt` preset near 0xFFFF.
  - Required: all outputs 0 immediately on reset; `bubble_cnt` sticks at 0xFFFF.
